// File: rtl/comp_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comp_scheduler_pkg
// Description : Shared defaults and FSM state encoding for the comparator
//               scheduler. Contains no ports.
// Revision    : 1.0 - initial release
// ============================================================================
package comp_scheduler_pkg;

  localparam int c_WORD_LEN_DEF = 14;
  localparam int c_N_REQ_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/comp_scheduler_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin selector. The search starts at the
//               index after the last winner and wraps from N_REQ-1 to 0.
// Ports       : req_i      - request vector
//               last_i     - index of the previous winner
//               win_o      - one-hot winner (zero when no request)
//               win_idx_o  - index of the winner
//               valid_o    - at least one request is pending
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets 1..N_REQ from the last winner; the first hit wins, so the
  // last winner itself is only re-picked when it is the sole requester.
  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    valid_o   = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = int'(last_i) + off;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = cand[IDX_W-1:0];
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        win_idx_o       = cand_idx;
        win_o[cand_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/comp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : comp_scheduler
// Description : Arbitrates N_REQ requesters onto one external comparator.
//               Sequence per compare: IDLE (arbitrate, latch operands) ->
//               LOAD (enable comparator) -> SAMPLE (capture result) ->
//               RESP (pulse ack). All outputs are registered.
// Ports       : clk, reset_n           - clock, async active-low reset
//               req, req_a, req_b      - per-requester request and operands
//               ack, res_gt/lt/eq      - completion pulse and result
//               grant, busy            - current owner, not-idle flag
//               cmp_in1/in2/enable     - drive to the shared comparator
//               cmp_gt/lt/eq           - comparator result inputs
// Revision    : 1.0 - initial release
// ============================================================================
module comp_scheduler
  import comp_scheduler_pkg::*;
#(
  parameter int WORD_LEN = c_WORD_LEN_DEF,
  parameter int N_REQ    = c_N_REQ_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*WORD_LEN-1:0] req_a,
  input  logic [N_REQ*WORD_LEN-1:0] req_b,
  output logic [N_REQ-1:0]          ack,
  output logic                      res_gt,
  output logic                      res_lt,
  output logic                      res_eq,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic [WORD_LEN-1:0]       cmp_in1,
  output logic [WORD_LEN-1:0]       cmp_in2,
  output logic                      cmp_enable,
  input  logic                      cmp_gt,
  input  logic                      cmp_lt,
  input  logic                      cmp_eq
);

  localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e              state_q;
  logic [c_IDX_W-1:0]  ptr_q;
  logic [N_REQ-1:0]    grant_q;
  logic [N_REQ-1:0]    ack_q;
  logic                busy_q;
  logic                cmp_en_q;
  logic                res_gt_q;
  logic                res_lt_q;
  logic                res_eq_q;
  logic [WORD_LEN-1:0] cmp_in1_q;
  logic [WORD_LEN-1:0] cmp_in2_q;

  logic [N_REQ-1:0]    pick_onehot;
  logic [c_IDX_W-1:0]  pick_idx;
  logic                pick_valid;

  logic [WORD_LEN-1:0] a_arr [N_REQ];
  logic [WORD_LEN-1:0] b_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WORD_LEN +: WORD_LEN];
      assign b_arr[gi] = req_b[gi*WORD_LEN +: WORD_LEN];
    end
  endgenerate

  rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (c_IDX_W)
  ) u_rr_picker (
    .req_i     (req),
    .last_i    (ptr_q),
    .win_o     (pick_onehot),
    .win_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      // Pointer parks on the last index so index 0 is searched first.
      ptr_q     <= c_IDX_W'(N_REQ - 1);
      grant_q   <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      cmp_en_q  <= 1'b0;
      res_gt_q  <= 1'b0;
      res_lt_q  <= 1'b0;
      res_eq_q  <= 1'b0;
      cmp_in1_q <= '0;
      cmp_in2_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q   <= pick_onehot;
            ptr_q     <= pick_idx;
            // Operands are captured here only; later input changes are ignored.
            cmp_in1_q <= a_arr[pick_idx];
            cmp_in2_q <= b_arr[pick_idx];
            busy_q    <= 1'b1;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cmp_en_q <= 1'b1;
          state_q  <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          res_gt_q <= cmp_gt;
          res_lt_q <= cmp_lt;
          res_eq_q <= cmp_eq;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          // Ack is issued whether or not the winner still holds req.
          ack_q    <= grant_q;
          grant_q  <= '0;
          cmp_en_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign cmp_enable = cmp_en_q;
  assign res_gt     = res_gt_q;
  assign res_lt     = res_lt_q;
  assign res_eq     = res_eq_q;
  assign cmp_in1    = cmp_in1_q;
  assign cmp_in2    = cmp_in2_q;

endmodule
`default_nettype wire

// File: tb/tb_comp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_comp_scheduler
// Description : Directed self-checking bench for comp_scheduler with a
//               behavioural model of the external unsigned comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_scheduler;

  localparam int WL = 14;
  localparam int NR = 4;

  logic          clk;
  logic          reset_n;
  logic [NR-1:0] req;
  logic [NR*WL-1:0] req_a;
  logic [NR*WL-1:0] req_b;
  logic [NR-1:0] ack;
  logic          res_gt, res_lt, res_eq;
  logic [NR-1:0] grant;
  logic          busy;
  logic [WL-1:0] cmp_in1, cmp_in2;
  logic          cmp_enable;
  logic          cmp_gt, cmp_lt, cmp_eq;

  int checks = 0;
  int errors = 0;

  comp_scheduler #(.WORD_LEN(WL), .N_REQ(NR)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .ack        (ack),
    .res_gt     (res_gt),
    .res_lt     (res_lt),
    .res_eq     (res_eq),
    .grant      (grant),
    .busy       (busy),
    .cmp_in1    (cmp_in1),
    .cmp_in2    (cmp_in2),
    .cmp_enable (cmp_enable),
    .cmp_gt     (cmp_gt),
    .cmp_lt     (cmp_lt),
    .cmp_eq     (cmp_eq)
  );

  // External comparator: unsigned, outputs gated by enable.
  assign cmp_gt = cmp_enable && (cmp_in1 >  cmp_in2);
  assign cmp_lt = cmp_enable && (cmp_in1 <  cmp_in2);
  assign cmp_eq = cmp_enable && (cmp_in1 == cmp_in2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [WL-1:0] a, input logic [WL-1:0] b);
    req_a[i*WL +: WL] = a;
    req_b[i*WL +: WL] = b;
  endtask

  task automatic do_reset();
    req     = '0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = '0;
    req_a   = '0;
    req_b   = '0;
    tick();
    tick();
    checks++;
    if ({grant, ack, busy, cmp_enable, res_gt, res_lt, res_eq} !== 11'd0 ||
        cmp_in1 !== '0 || cmp_in2 !== '0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b ack=%b busy=%b en=%b res=%b%b%b in1=%h in2=%h, want all 0",
               grant, ack, busy, cmp_enable, res_gt, res_lt, res_eq, cmp_in1, cmp_in2);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b grant=%b, want 0/0000", busy, grant);
    end
  endtask

  task automatic test_single();
    set_ops(1, 14'd100, 14'd50);
    req = 4'b0010;
    tick();
    checks++;
    if (grant !== 4'b0010 || busy !== 1'b1 || cmp_in1 !== 14'd100 ||
        cmp_in2 !== 14'd50 || cmp_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: grant=%b busy=%b in1=%0d in2=%0d en=%b, want 0010 1 100 50 0",
               grant, busy, cmp_in1, cmp_in2, cmp_enable);
    end
    tick();
    checks++;
    if (cmp_enable !== 1'b1 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_load: en=%b ack=%b, want 1 0000", cmp_enable, ack);
    end
    tick();
    checks++;
    if (cmp_enable !== 1'b1 || ack !== 4'b0000 || res_gt !== 1'b1) begin
      errors++;
      $display("FAIL single_sample: en=%b ack=%b gt=%b, want 1 0000 1", cmp_enable, ack, res_gt);
    end
    tick();
    checks++;
    if (ack !== 4'b0010 || grant !== 4'b0000 || cmp_enable !== 1'b0 ||
        busy !== 1'b0 || {res_gt, res_lt, res_eq} !== 3'b100) begin
      errors++;
      $display("FAIL single_ack: ack=%b grant=%b en=%b busy=%b res=%b%b%b, want 0010 0000 0 0 100",
               ack, grant, cmp_enable, busy, res_gt, res_lt, res_eq);
    end
    req = '0;
    tick();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || {res_gt, res_lt, res_eq} !== 3'b100) begin
      errors++;
      $display("FAIL single_after: ack=%b busy=%b res=%b%b%b, want 0000 0 100 held",
               ack, busy, res_gt, res_lt, res_eq);
    end
  endtask

  task automatic test_unsigned();
    set_ops(0, 14'h3FFF, 14'h0001);
    req = 4'b0001;
    for (int t = 0; t < 4; t++) tick();
    req = '0;
    checks++;
    if (ack !== 4'b0001 || {res_gt, res_lt, res_eq} !== 3'b100) begin
      errors++;
      $display("FAIL unsigned_max: ack=%b res=%b%b%b, want 0001 100", ack, res_gt, res_lt, res_eq);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [NR-1:0] exp_ack;
    logic          early;
    do_reset();
    for (int i = 0; i < NR; i++) set_ops(i, 14'h3FFF, 14'h3FFF);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      early = 1'b0;
      for (int t = 0; t < 3; t++) begin
        tick();
        if (ack !== 4'b0000) early = 1'b1;
      end
      tick();
      exp_ack = 4'b0001 << (k % NR);
      if (k == 4) req = '0;
      checks++;
      if (early || ack !== exp_ack || res_eq !== 1'b1) begin
        errors++;
        $display("FAIL rr_order_%0d: ack=%b early=%b eq=%b, want %b no-early 1",
                 k, ack, early, res_eq, exp_ack);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL rr_drain: busy=%b ack=%b, want 0 0000", busy, ack);
    end
  endtask

  task automatic test_latched_operands();
    set_ops(2, 14'd0, 14'h3FFF);
    req = 4'b0100;
    tick();
    set_ops(2, 14'h3FFF, 14'h3FFF);
    tick();
    tick();
    tick();
    req = '0;
    checks++;
    if (ack !== 4'b0100 || {res_gt, res_lt, res_eq} !== 3'b010 || cmp_in1 !== 14'd0) begin
      errors++;
      $display("FAIL latched_ops: ack=%b res=%b%b%b in1=%h, want 0100 010 0000",
               ack, res_gt, res_lt, res_eq, cmp_in1);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic early;
    set_ops(3, 14'd7, 14'd9);
    req = 4'b1000;
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL mid_grant: grant=%b, want 1000", grant);
    end
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({grant, ack, busy, cmp_enable, res_gt, res_lt, res_eq} !== 11'd0 ||
        cmp_in1 !== '0 || cmp_in2 !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: grant=%b ack=%b busy=%b en=%b res=%b%b%b in1=%h in2=%h, want all 0",
               grant, ack, busy, cmp_enable, res_gt, res_lt, res_eq, cmp_in1, cmp_in2);
    end
    tick();
    tick();
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_noack: ack=%b busy=%b, want 0000 0", ack, busy);
    end
    reset_n = 1'b1;
    early = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (ack !== 4'b0000) early = 1'b1;
    end
    tick();
    req = '0;
    checks++;
    if (early || ack !== 4'b1000 || {res_gt, res_lt, res_eq} !== 3'b010) begin
      errors++;
      $display("FAIL mid_reserve: ack=%b early=%b res=%b%b%b, want 1000 no-early 010",
               ack, early, res_gt, res_lt, res_eq);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_ops(0, 14'd1, 14'd2);
    set_ops(3, 14'd3, 14'd2);
    req = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL simul_first_grant: grant=%b, want 0001", grant);
    end
    tick();
    tick();
    tick();
    req = 4'b1000;
    checks++;
    if (ack !== 4'b0001 || {res_gt, res_lt, res_eq} !== 3'b010) begin
      errors++;
      $display("FAIL simul_first_ack: ack=%b res=%b%b%b, want 0001 010", ack, res_gt, res_lt, res_eq);
    end
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      errors++;
      $display("FAIL simul_second_grant: grant=%b, want 1000", grant);
    end
    tick();
    tick();
    tick();
    req = '0;
    checks++;
    if (ack !== 4'b1000 || {res_gt, res_lt, res_eq} !== 3'b100) begin
      errors++;
      $display("FAIL simul_second_ack: ack=%b res=%b%b%b, want 1000 100", ack, res_gt, res_lt, res_eq);
    end
    tick();
  endtask

  task automatic test_idle();
    req = '0;
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || cmp_enable !== 1'b0 || grant !== 4'b0000) begin
        errors++;
        $display("FAIL idle_cycle_%0d: busy=%b en=%b grant=%b, want 0 0 0000",
                 t, busy, cmp_enable, grant);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_unsigned();
    test_back_to_back();
    test_latched_operands();
    test_reset_mid();
    test_simultaneous();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/comp_scheduler.md
COMP_SCHEDULER -- requirements
Module: comp_scheduler

Interface
REQ-001 Parameter WORD_LEN, default 14, operand width in bits.
REQ-002 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  N_REQ  per-requester compare request, level, held until ack.
REQ-006 req_a  input  N_REQ*WORD_LEN  packed operand A; slice i belongs to requester i.
REQ-007 req_b  input  N_REQ*WORD_LEN  packed operand B; slice i belongs to requester i.
REQ-008 ack  output  N_REQ  one-hot, one-cycle pulse; result valid for that requester.
REQ-009 res_gt, res_lt, res_eq  output  1 each  registered result of the acked compare.
REQ-010 grant  output  N_REQ  one-hot owner of the comparator, zero when idle.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 cmp_in1, cmp_in2  output  WORD_LEN each  operands to the shared comparator.
REQ-013 cmp_enable  output  1  enable to the shared comparator.
REQ-014 cmp_gt, cmp_lt, cmp_eq  input  1 each  combinational outputs of the shared comparator.

Function
REQ-015 FSM states IDLE, LOAD, SAMPLE, RESP; all outputs are registered.
REQ-016 IDLE: if any req bit is set, pick a winner round-robin, set grant, latch its req_a into cmp_in1 and its req_b into cmp_in2, and go to LOAD.
REQ-017 LOAD: assert cmp_enable, then go to SAMPLE.
REQ-018 SAMPLE: keep cmp_enable high, capture cmp_gt/lt/eq into res_*, then go to RESP.
REQ-019 RESP: pulse ack[grant] for exactly one cycle, deassert cmp_enable, clear grant, then go to IDLE.
REQ-020 Latency from req sampled high in IDLE to ack is 3 cycles; maximum throughput is one compare per 4 cycles.
REQ-021 Round-robin: search starts at the index after the last winner, wrapping from N_REQ-1 to 0; after reset the pointer starts at index 0.
REQ-022 A requester SHALL drop req in the cycle after its ack; a req still high in IDLE is treated as a new request.
REQ-023 Operands are latched once in IDLE; changes on req_a/req_b during LOAD, SAMPLE or RESP SHALL NOT affect the result.
REQ-024 A winner that drops req mid-compare still completes; ack and the result are issued regardless.
REQ-025 New req bits arriving while busy are ignored until the next IDLE arbitration.
REQ-026 res_* hold their value until the next SAMPLE; exactly one res_* bit is high after the first compare.
REQ-027 Comparison is unsigned over the full WORD_LEN bits; there is no truncation or sign extension.
REQ-028 The scheduler SHALL stay in IDLE with cmp_enable low while req is all zero.

Reset
REQ-029 While reset_n is low, the FSM is IDLE and grant, ack, cmp_enable, res_*, cmp_in1 and cmp_in2 are all 0; the RR pointer selects index 0 first.
REQ-030 Reset asserted mid-compare aborts the operation with no ack; after release the requester must still hold req to be re-served.
REQ-031 Reset release SHALL take effect at the first rising clk edge after reset_n goes high.

Structure
REQ-032 Shared package holds WORD_LEN, N_REQ defaults and the FSM state encoding (2-bit: IDLE=0, LOAD=1, SAMPLE=2, RESP=3).
REQ-033 Round-robin selection is sub-module rr_picker (inputs: req, last-winner pointer; output: one-hot winner plus index), purely combinational.
REQ-034 The comparator is external to comp_scheduler; the top level wires cmp_* ports to it.

Verification
REQ-035 Single req[1]=1, a=100, b=50 -> grant=0010 one cycle later; ack[1] pulses 3 cycles after req sampled; res_gt=1.
REQ-036 req=1111 held, all a=b=0x3FFF -> acks in order 0,1,2,3,0 at 4-cycle spacing; res_eq=1 each time.
REQ-037 req[2] with a=0, b=0x3FFF, then req_a changed to 0x3FFF during LOAD -> res_lt=1 (latched operands used).
REQ-038 reset_n low during SAMPLE of req[3] -> no ack, all outputs 0; after release with req[3] still high -> serviced, ack[3] 3 cycles after first IDLE cycle.
REQ-039 req[0] and req[3] rising in the same cycle after reset -> req[0] served first, req[3] next.
REQ-040 Idle bench with req=0 for 20 cycles -> busy=0, cmp_enable=0, grant=0 throughout.
